// File: rtl/div_frontend.sv
// Divide front-end: resolves divide-by-zero and signed overflow locally, issues
// unsigned magnitudes to the SRT core and restores result signs on capture.
module div_frontend #(
    parameter int DW    = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [1:0]       in_op_i,
    input  logic [DW-1:0]    in_a_i,
    input  logic [DW-1:0]    in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [DW-1:0]    out_res_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             core_vld_o,
    output logic [63:0]      core_op1_o,
    output logic [63:0]      core_op2_o,
    input  logic             core_ready_i,
    input  logic [63:0]      core_quo_i,
    input  logic [63:0]      core_rem_i
);

    // state | meaning
    // IDLE  | accepting a request
    // ISSUE | core_vld_o held until the core shows ready
    // BUSY  | waiting for the core to drop ready (acknowledge)
    // DONE  | waiting for the core to raise ready again, then capture
    // OUT   | result presented until the consumer takes it
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, OUT} state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q;
    logic             sa_q, sb_q;
    logic [DW-1:0]    res_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      op1_q, op2_q;

    logic             accept;
    logic             is_signed, sa, sb, bz, ovf;
    logic [DW:0]      mag_a, mag_b;
    logic [DW-1:0]    raw, res_fix;
    logic             neg;
    logic             core_hi_unused;

    assign accept    = (state_q == IDLE) && in_vld_i;
    assign is_signed = ~in_op_i[0];
    assign sa        = is_signed & in_a_i[DW-1];
    assign sb        = is_signed & in_b_i[DW-1];
    assign bz        = ~|in_b_i;
    assign ovf       = is_signed & (in_a_i == {1'b1, {(DW-1){1'b0}}}) & (&in_b_i);

    // One extra bit so the most negative operand still has a representable magnitude.
    assign mag_a = sa ? -{1'b1, in_a_i} : {1'b0, in_a_i};
    assign mag_b = sb ? -{1'b1, in_b_i} : {1'b0, in_b_i};

    assign raw     = op_q[1] ? core_rem_i[DW-1:0] : core_quo_i[DW-1:0];
    assign neg     = op_q[1] ? sa_q : (sa_q ^ sb_q);
    assign res_fix = neg ? -raw : raw;

    assign core_hi_unused = ^{core_quo_i[63:DW], core_rem_i[63:DW]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_vld_i) state_d = (bz || ovf) ? OUT : ISSUE;
            ISSUE:   if (core_ready_i) state_d = BUSY;
            BUSY:    if (!core_ready_i) state_d = DONE;
            DONE:    if (core_ready_i) state_d = OUT;
            OUT:     if (out_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q  <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            res_q <= '0;
            tag_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            op_q  <= in_op_i;
            sa_q  <= sa;
            sb_q  <= sb;
            tag_q <= in_tag_i;
            if (bz) begin
                res_q <= in_op_i[1] ? in_a_i : '1;
            end else if (ovf) begin
                res_q <= in_op_i[1] ? '0 : in_a_i;
            end else begin
                op1_q <= 64'(mag_a);
                op2_q <= 64'(mag_b);
            end
        end else if (state_q == DONE && core_ready_i) begin
            res_q <= res_fix;
        end
    end

    assign in_rdy_o   = (state_q == IDLE);
    assign out_vld_o  = (state_q == OUT);
    assign core_vld_o = (state_q == ISSUE);
    assign out_res_o  = res_q;
    assign out_tag_o  = tag_q;
    assign core_op1_o = op1_q;
    assign core_op2_o = op2_q;

endmodule

// File: tb/tb_div_frontend.sv
// Scoreboard bench for div_frontend with a variable-latency behavioural core.
module tb_div_frontend;
    localparam int DW = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_vld_i = 1'b0;
    logic             in_rdy_o;
    logic [1:0]       in_op_i = '0;
    logic [DW-1:0]    in_a_i = '0;
    logic [DW-1:0]    in_b_i = '0;
    logic [TAG_W-1:0] in_tag_i = '0;
    logic             out_vld_o;
    logic             out_rdy_i = 1'b1;
    logic [DW-1:0]    out_res_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             core_vld_o;
    logic [63:0]      core_op1_o, core_op2_o;
    logic             core_ready_i;
    logic [63:0]      core_quo_i, core_rem_i;

    div_frontend #(.DW(DW), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_op_i(in_op_i),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_tag_i(in_tag_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_res_o(out_res_o), .out_tag_o(out_tag_o),
        .core_vld_o(core_vld_o), .core_op1_o(core_op1_o), .core_op2_o(core_op2_o),
        .core_ready_i(core_ready_i), .core_quo_i(core_quo_i), .core_rem_i(core_rem_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    logic [TAG_W+DW-1:0] exp_q[$];

    // behavioural core: ready drops after issue, rises after a random delay
    logic        core_stuck = 1'b0;
    logic        c_busy;
    int          c_cnt;
    int          issue_cnt = 0;
    logic [63:0] last_op1 = '0, last_op2 = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_ready_i <= 1'b1;
            c_busy       <= 1'b0;
            c_cnt        <= 0;
            core_quo_i   <= '0;
            core_rem_i   <= '0;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                core_ready_i <= 1'b1;
                c_busy       <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (core_vld_o && core_ready_i && !core_stuck) begin
            core_ready_i <= 1'b0;
            c_busy       <= 1'b1;
            c_cnt        <= int'($urandom_range(0, 5));
            core_quo_i   <= core_op1_o / core_op2_o;
            core_rem_i   <= core_op1_o % core_op2_o;
        end
    end

    always @(posedge clk) begin
        if (core_vld_o && core_ready_i) begin
            issue_cnt <= issue_cnt + 1;
            last_op1  <= core_op1_o;
            last_op2  <= core_op2_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa_i, sb_i;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        if (!op[0]) begin
            sa_i = $signed(a);
            sb_i = $signed(b);
            return op[1] ? 32'(sa_i % sb_i) : 32'(sa_i / sb_i);
        end
        return op[1] ? a % b : a / b;
    endfunction

    // called at a negedge; returns just after the accepting posedge
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] exp);
        int n = 0;
        in_vld_i = 1'b1; in_op_i = op; in_a_i = a; in_b_i = b; in_tag_i = tag;
        while (!in_rdy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy_o) check("send_timeout", {63'b0, in_rdy_o}, 64'd1);
        @(posedge clk);
        exp_q.push_back({tag, exp});
    endtask

    // called at a negedge; returns just after the output handshake posedge
    task automatic collect();
        int n = 0;
        logic [TAG_W+DW-1:0] e;
        while (!out_vld_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_vld_o) begin
            check("out_timeout", {63'b0, out_vld_o}, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
            @(posedge clk);
            return;
        end
        e = exp_q.pop_front();
        check("res", 64'(out_res_o), 64'(e[DW-1:0]));
        check("tag", 64'(out_tag_o), 64'(e[TAG_W+DW-1:DW]));
        @(posedge clk);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp, input bit bypass);
        int ic0;
        @(negedge clk);
        ic0 = issue_cnt;
        send(op, a, b, tag, exp);
        @(negedge clk);
        in_vld_i = 1'b0;
        if (bypass) check("bypass_lat", {63'b0, out_vld_o}, 64'd1);
        collect();
        check(bypass ? "no_issue" : "one_issue", 64'(issue_cnt), 64'(bypass ? ic0 : ic0 + 1));
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          byp;

        #1;
        check("rst_in_rdy",  {63'b0, in_rdy_o}, 64'd1);
        check("rst_out_vld", {63'b0, out_vld_o}, 64'd0);
        check("rst_out_res", 64'(out_res_o), 64'd0);
        check("rst_out_tag", 64'(out_tag_o), 64'd0);
        check("rst_core_vld", {63'b0, core_vld_o}, 64'd0);
        check("rst_op1", core_op1_o, 64'd0);
        check("rst_op2", core_op2_o, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 4'h5, 32'hFFFF_FFFD, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'hA, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h10, 4'h3, 32'h0FFF_FFFF, 0);
        check("issue_op1", last_op1, 64'h0000_0000_FFFF_FFFF);
        check("issue_op2", last_op2, 64'h10);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 4'h4, 32'h0000_000F, 0);

        run_op(2'b00, 32'h0000_1234, 32'd0, 4'h1, 32'hFFFF_FFFF, 1);
        run_op(2'b01, 32'h8765_4321, 32'd0, 4'h2, 32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'h0000_1234, 32'd0, 4'h6, 32'h0000_1234, 1);
        run_op(2'b11, 32'h0000_1234, 32'd0, 4'h7, 32'h0000_1234, 1);

        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 32'h8000_0000, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 32'h0, 1);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, 32'h0, 0);
        run_op(2'b00, 32'h8000_0000, 32'd3, 4'hC, 32'hD555_5556, 0);
        check("issue_op1_min", last_op1, 64'h0000_0000_8000_0000);
        check("issue_op2_min", last_op2, 64'h3);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            byp = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            run_op(op, a, b, 4'(i), ref_res(op, a, b), byp);
        end

        // backpressure with a competing request offered while the result is held
        @(negedge clk);
        out_rdy_i = 1'b0;
        send(2'b01, 32'd1000, 32'd7, 4'h3, 32'd142);
        @(negedge clk);
        in_vld_i = 1'b0;
        for (int n = 0; n < 200 && !out_vld_o; n++) @(negedge clk);
        in_vld_i = 1'b1; in_op_i = 2'b00; in_a_i = 32'hFFFF_FF9C; in_b_i = 32'd7; in_tag_i = 4'h9;
        for (int n = 0; n < 10; n++) begin
            check("bp_vld", {63'b0, out_vld_o}, 64'd1);
            check("bp_res", 64'(out_res_o), 64'd142);
            check("bp_tag", 64'(out_tag_o), 64'h3);
            check("bp_in_rdy", {63'b0, in_rdy_o}, 64'd0);
            @(negedge clk);
        end
        out_rdy_i = 1'b1;
        collect();
        @(negedge clk);
        check("bp_rdy_after", {63'b0, in_rdy_o}, 64'd1);
        check("bp_vld_after", {63'b0, out_vld_o}, 64'd0);
        @(posedge clk);
        exp_q.push_back({4'h9, 32'hFFFF_FFF2});
        @(negedge clk);
        in_vld_i = 1'b0;
        collect();

        // core that never acknowledges: block parks in BUSY until reset
        @(negedge clk);
        core_stuck = 1'b1;
        send(2'b01, 32'd50, 32'd5, 4'hE, 32'd10);
        @(negedge clk);
        in_vld_i = 1'b0;
        repeat (20) @(negedge clk);
        check("stuck_out_vld", {63'b0, out_vld_o}, 64'd0);
        check("stuck_in_rdy", {63'b0, in_rdy_o}, 64'd0);
        check("stuck_core_vld", {63'b0, core_vld_o}, 64'd0);
        rstn = 1'b0;
        core_stuck = 1'b0;
        #1;
        check("mid_rst_in_rdy", {63'b0, in_rdy_o}, 64'd1);
        check("mid_rst_out_vld", {63'b0, out_vld_o}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        run_op(2'b01, 32'd100, 32'd7, 4'hD, 32'd14, 0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_frontend.md
# div_frontend

Signed/unsigned divide front-end placed between the execute-stage issue logic and the radix-4 SRT divider core. It accepts RISC-V style DIV/DIVU/REM/REMU requests on DW-bit operands. It resolves divide-by-zero and signed overflow locally, and converts signed operands to zero-extended 64-bit magnitudes for the core. It restores result signs and holds one result under a valid/ready handshake until the consumer takes it. One operation is in flight at a time.

## Interface
- DW, 32: operand/result width; must be ≤ 63 so core operands always have bit 63 = 0.
- TAG_W, 4: width of the opaque tag carried from request to result.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_vld_i  in  1  request valid.
- in_rdy_o  out  1  request ready; the request transfers when in_vld_i & in_rdy_o.
- in_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a_i  in  DW  dividend.
- in_b_i  in  DW  divisor.
- in_tag_i  in  TAG_W  request tag.
- out_vld_o  out  1  result valid.
- out_rdy_i  in  1  consumer ready.
- out_res_o  out  DW  quotient for DIV/DIVU, remainder for REM/REMU.
- out_tag_o  out  TAG_W  tag of the result.
- core_vld_o  out  1  issue strobe to the core.
- core_op1_o  out  64  dividend magnitude, zero-extended.
- core_op2_o  out  64  divisor magnitude, zero-extended.
- core_ready_i  in  1  core idle/ready.
- core_quo_i  in  64  core quotient.
- core_rem_i  in  64  core remainder.

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE, OUT.
- IDLE: in_rdy_o = 1. On accept, register op, a, b and tag, and compute the flags below:
  - signed = ~op[0].
  - sa = signed & a[DW-1]; sb = signed & b[DW-1].
  - Magnitudes: |a| = sa ? -a : a; |b| = sb ? -b : b, both DW+1 wide unsigned, then zero-extended to 64.
  - bz = (b == 0).
  - ovf = signed & (a == 1<<(DW-1)) & (b == all-ones).
- Next state after IDLE:
  - bz or ovf: go to OUT with the bypass result, no core issue.
  - Otherwise: go to ISSUE.
- Bypass results:
  - bz: quotient = all-ones (DW bits); remainder = a.
  - ovf: quotient = a; remainder = 0.
- ISSUE: hold core_vld_o = 1 with core_op1_o = |a| and core_op2_o = |b| until a cycle with core_ready_i = 1. That cycle is the issue transfer; then go to BUSY.
- BUSY: wait for core_ready_i = 0, which is the core acknowledging. Then go to DONE.
- DONE: wait for core_ready_i = 1. On that cycle, capture core_quo_i[DW-1:0] or core_rem_i[DW-1:0] according to op. Then go to OUT.
- Sign restoration, applied at capture:
  - DIV: negate the quotient when sa ^ sb.
  - REM: negate the remainder when sa.
  - Unsigned ops: no change.
  - All arithmetic is modulo 2^DW.
- OUT: out_vld_o = 1 with out_res_o and out_tag_o stable. On out_vld_o & out_rdy_i, go to IDLE.
- Outputs outside their states:
  - core_vld_o = 0 outside ISSUE.
  - core_op1_o and core_op2_o hold their last values.
- No new request is accepted in ISSUE, BUSY, DONE or OUT; in_rdy_o = 0 there.

## Timing
- Reset values: state IDLE; in_rdy_o = 1; out_vld_o = 0; out_res_o = 0; out_tag_o = 0; core_vld_o = 0; core_op1_o = 0; core_op2_o = 0.
- in_rdy_o, out_vld_o and core_vld_o are registered, i.e. decoded from registered state. There is no combinational path from in_vld_i to in_rdy_o.
- Bypass latency: accept at edge N; out_vld_o = 1 from cycle N+1.
- Core-path latency: accept at N, then ISSUE from N+1. Core latency is variable, depending on operand leading-digit distance. out_vld_o rises one cycle after the DONE capture cycle.
- Result held while out_rdy_i = 0. Back-to-back: in_rdy_o rises the cycle after the OUT handshake, giving one bubble.
- Reset asserted mid-operation:
  - All state returns to IDLE asynchronously and the pending result is discarded.
  - The core is reset by the same rstn, so there is no stale completion.
- core_ready_i stuck at 1 after issue: the block stays in BUSY indefinitely. It never captures a result without seeing the 0→1 transition.
- DW = 32 signed extremes: |0x80000000| = 0x080000000 (33 bits), which is legal core input.

## Test plan
- DIV a = -7 (0xFFFFFFF9), b = 2: out_res_o = 0xFFFFFFFD (-3). REM on the same operands: 0xFFFFFFFF (-1). out_tag_o equals in_tag_i.
- DIVU a = 0xFFFFFFFF, b = 0x10: out_res_o = 0x0FFFFFFF. REMU on the same operands: 0x0000000F. core_op1_o = 0x00000000FFFFFFFF at issue.
- Any op with b = 0:
  - DIV and DIVU: out_res_o = 0xFFFFFFFF.
  - REM with a = 0x1234: out_res_o = 0x1234.
  - No core_vld_o pulse in any case; out_vld_o asserted one cycle after accept.
- DIV a = 0x80000000, b = 0xFFFFFFFF: out_res_o = 0x80000000 via bypass. REM on the same operands: out_res_o = 0. DIVU on the same operands goes through the core and returns 0.
- Backpressure: hold out_rdy_i = 0 for 10 cycles after out_vld_o.
  - out_res_o and out_tag_o stay stable and in_rdy_o stays 0.
  - A request offered during those cycles is not accepted until the cycle after the handshake.
- Reset pulse during BUSY: in_rdy_o = 1 and out_vld_o = 0 immediately. A following DIVU 100/7 returns 14.
